blwl_bank_programmer: RTL

BLWL_BANK_PROGRAMMER -- requirements
Module: blwl_bank_programmer

---
 rtl/blwl_bank_programmer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/blwl_bank_programmer.sv
// Bit-line / word-line programmer: writes one word into a bank row using a
// setup / WL pulse / hold sequence with all outputs registered.
module blwl_bank_programmer #(
  parameter  int NUM_BL    = 8,
  parameter  int NUM_WL    = 4,
  parameter  int SETUP_CYC = 1,
  parameter  int PULSE_CYC = 2,
  parameter  int HOLD_CYC  = 1,
  localparam int AW        = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [AW-1:0]     cfg_wl_addr,
  input  logic [NUM_BL-1:0] cfg_data,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_BL-1:0] blb,
  output logic [NUM_WL-1:0] wl,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [15:0]       words_written
);

  localparam int MAXC = (SETUP_CYC > PULSE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  // Per-address legality table; avoids a width-limited constant compare when
  // NUM_WL is a power of two.
  function automatic logic [(1<<AW)-1:0] addr_ok_mask();
    logic [(1<<AW)-1:0] m;
    for (int i = 0; i < (1 << AW); i++) m[i] = (i < NUM_WL);
    return m;
  endfunction
  localparam logic [(1<<AW)-1:0] ADDR_OK = addr_ok_mask();

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [NUM_WL-1:0]  sel, sel_n, dec;
  logic [NUM_BL-1:0]  bl_n, blb_n;
  logic [NUM_WL-1:0]  wl_n;
  logic               busy_n, done_n, err_n, ready_n;
  logic [15:0]        count_q;
  logic               accept, addr_ok, phase_end;

  assign accept    = cfg_valid && cfg_ready;
  assign addr_ok   = ADDR_OK[cfg_wl_addr];
  assign phase_end = (cnt == '0);

  for (genvar i = 0; i < NUM_WL; i++) begin : g_dec
    assign dec[i] = (cfg_wl_addr == AW'(i));
  end

  // State register and the shared phase timer
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state; the timer reloads on every state entry
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && addr_ok) state_n = SETUP;
      SETUP:   if (phase_end)         state_n = PULSE;
      PULSE:   if (phase_end)         state_n = HOLD;
      HOLD:    if (phase_end)         state_n = IDLE;
      default:                        state_n = IDLE;
    endcase
    if (state_n != state) begin
      case (state_n)
        SETUP:   cnt_n = SETUP_LD;
        PULSE:   cnt_n = PULSE_LD;
        HOLD:    cnt_n = HOLD_LD;
        default: cnt_n = '0;
      endcase
    end else begin
      cnt_n = phase_end ? cnt : cnt - 1'b1;
    end
  end

  // Next output values; bl/blb double as the captured data word
  always_comb begin
    bl_n  = bl;
    blb_n = blb;
    sel_n = sel;
    if (state == IDLE && state_n == SETUP) begin
      bl_n  = cfg_data;
      blb_n = ~cfg_data;
      sel_n = dec;
    end else if (state_n == IDLE) begin
      bl_n  = '0;
      blb_n = '0;
    end
    wl_n    = (state_n == PULSE) ? sel_n : '0;
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
    done_n  = (state == HOLD) && (state_n == IDLE);
    err_n   = (state == IDLE) && accept && !addr_ok;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      bl        <= '0;
      blb       <= '0;
      wl        <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      cfg_ready <= 1'b0;
      count_q   <= '0;
    end else begin
      bl        <= bl_n;
      blb       <= blb_n;
      wl        <= wl_n;
      sel       <= sel_n;
      busy      <= busy_n;
      done      <= done_n;
      addr_err  <= err_n;
      cfg_ready <= ready_n;
      count_q   <= count_q + 16'(done_n);
    end
  end

  assign words_written = count_q;

endmodule
